note_chart_feeder: RTL and testbench

Supplies note times from the song-chart memory to the note-matching logic, one lane per instance. It prefetches upcoming note times into a small FIFO and presents the head on `note_time`. Each `note_request` pulse from the matcher pops the head. When no note is buffered, `note_time` reads all ones; once the chart ends, it stays all ones.

---
 rtl/note_chart_feeder.sv | 138 +++++++++++++
 tb/tb_note_chart_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_feeder.sv
// Per-lane chart feeder: prefetches note times from chart memory into a small FIFO
// and presents the head to the matcher. Define NOTE_FEEDER_UNDERRUN_EN to build underrun detection.
module note_chart_feeder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  note_request,
   output logic [17:0]           note_time,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [17:0]           mem_data,
   output logic                  busy,
   output logic                  chart_done,
   output logic                  underrun
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state, state_n;
   logic [17:0]       fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [CW-1:0]     occ, occ_n, cnt_n;
   // vld_pipe[k]: a read issued k cycles ago is outstanding; it returns at k == MEM_LATENCY
   logic [MEM_LATENCY:1] vld_pipe, last_pipe, vld_n, last_n;
   logic              ceil_hit, ceil_n;
   logic              ret_vld, ret_sent, ret_last, push, pop, end_hit, issue_last, rd_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [17:0]       head_n;

   always_comb begin
      ret_vld    = vld_pipe[MEM_LATENCY];
      ret_sent   = ret_vld && (mem_data == 18'h3FFFF);
      ret_last   = ret_vld && last_pipe[MEM_LATENCY];
      push       = ret_vld && !ret_sent;
      end_hit    = ret_sent || ret_last;
      pop        = note_request && (occ != '0);
      issue_last = mem_rd && (mem_addr == '1);
      ceil_n     = ceil_hit || issue_last;
      addr_n     = (mem_rd && !issue_last) ? mem_addr + 1'b1 : mem_addr;
      occ_n      = occ + CW'(push) - CW'(pop);
      rd_ptr_n   = rd_ptr + PW'(pop);
      wr_ptr_n   = wr_ptr + PW'(push);

      // a sentinel return kills every younger read, including the one issuing now
      vld_n  = '0;
      last_n = '0;
      if (!ret_sent) begin
         for (int i = MEM_LATENCY; i > 1; i--) begin
            vld_n[i]  = vld_pipe[i-1];
            last_n[i] = last_pipe[i-1];
         end
         vld_n[1]  = mem_rd;
         last_n[1] = issue_last;
      end
      cnt_n = '0;
      for (int i = 1; i <= MEM_LATENCY; i++) cnt_n = cnt_n + CW'(vld_n[i]);

      state_n = state;
      if (state == FETCH && end_hit) state_n = DRAIN;
      if (state_n == DRAIN && occ_n == '0 && cnt_n == '0) state_n = DONE;

      rd_n = (state_n == FETCH) && !ceil_n && ((occ_n + cnt_n) < CW'(FIFO_DEPTH));

      // the new head may be the word being written this very cycle
      if (occ_n == '0)                    head_n = 18'h3FFFF;
      else if (push && wr_ptr == rd_ptr_n) head_n = mem_data;
      else                                 head_n = fifo_mem[rd_ptr_n];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occ        <= '0;
         vld_pipe   <= '0;
         last_pipe  <= '0;
         ceil_hit   <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         note_time  <= 18'h3FFFF;
         busy       <= 1'b0;
         chart_done <= 1'b0;
      end else if (start) begin
         state      <= FETCH;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occ        <= '0;
         vld_pipe   <= '0;
         last_pipe  <= '0;
         ceil_hit   <= 1'b0;
         mem_rd     <= 1'b1;
         mem_addr   <= base_addr;
         note_time  <= 18'h3FFFF;
         busy       <= 1'b1;
         chart_done <= 1'b0;
      end else begin
         state      <= state_n;
         rd_ptr     <= rd_ptr_n;
         wr_ptr     <= wr_ptr_n;
         occ        <= occ_n;
         vld_pipe   <= vld_n;
         last_pipe  <= last_n;
         ceil_hit   <= ceil_n;
         mem_rd     <= rd_n;
         mem_addr   <= addr_n;
         note_time  <= head_n;
         busy       <= (state_n == FETCH) || (state_n == DRAIN);
         chart_done <= (state_n == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!start && push) fifo_mem[wr_ptr] <= mem_data;
   end

`ifdef NOTE_FEEDER_UNDERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         underrun <= 1'b0;
      else if (start)
         underrun <= 1'b0;
      else if (note_request && occ == '0 && (state == FETCH || state == DRAIN))
         underrun <= 1'b1;
   end
`else
   assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_note_chart_feeder.sv
// Scoreboard bench for note_chart_feeder: expected note times are queued at start and
// compared as the matcher pops them; latency, read addresses and flags are checked directly.
module tb_note_chart_feeder;
   localparam int AW  = 12;
   localparam int LAT = 2;
`ifdef NOTE_FEEDER_UNDERRUN_EN
   localparam logic UR_EXP = 1'b1;
`else
   localparam logic UR_EXP = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, note_request = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [17:0]   note_time, mem_data;
   logic [AW-1:0] mem_addr;
   logic          mem_rd, busy, chart_done, underrun;

   int total = 0, bad = 0;
   logic [17:0]   mem [0:(1<<AW)-1];
   logic [AW-1:0] rp_a [LAT];
   logic [AW-1:0] rd_log [$];
   logic [17:0]   exp_q [$];

   note_chart_feeder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .note_request(note_request), .note_time(note_time), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy), .chart_done(chart_done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   // chart memory: address captured on each edge, data presented LAT cycles after mem_rd
   always @(posedge clk) begin
      for (int k = LAT-1; k > 0; k--) rp_a[k] <= rp_a[k-1];
      rp_a[0] <= mem_addr;
   end
   assign mem_data = mem[rp_a[LAT-1]];

   always @(posedge clk) if (rst_n && mem_rd) rd_log.push_back(mem_addr);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // returns at the negedge of cycle 1 after start
   task automatic do_start(input logic [AW-1:0] a);
      start = 1'b1; base_addr = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   // wait (bounded) for a head, compare it with the scoreboard, then pop it
   task automatic pop_one(input string tag);
      int w = 0;
      logic [17:0] e;
      while (note_time == 18'h3FFFF && w < 40) begin @(negedge clk); w++; end
      e = exp_q.pop_front();
      chk(tag, 32'(note_time), 32'(e));
      note_request = 1'b1;
      @(negedge clk);
      note_request = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int w = 0;
      while (!chart_done && w < 20) begin @(negedge clk); w++; end
      chk(tag, 32'(chart_done), 32'd1);
      chk({tag, "_nt"}, 32'(note_time), 32'h3FFFF);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 18'h3FFFF;
      mem[16] = 18'd100; mem[17] = 18'd250; mem[18] = 18'd400;
      for (int i = 0; i < 8; i++)  mem[200+i] = 18'(1000 + 7*i);
      for (int i = 0; i < 10; i++) mem[300+i] = 18'(5000 + i);
      mem[64] = 18'd7000; mem[65] = 18'd7001; mem[66] = 18'd7002;
      mem[4094] = 18'd11; mem[4095] = 18'd22;

      // reset values
      cyc(2);
      chk("rst_nt",   32'(note_time), 32'h3FFFF);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_rd",   32'(mem_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(chart_done), 32'd0);
      chk("rst_ur",   32'(underrun), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // prefetch fill
      rd_log.delete();
      exp_q = '{18'd100, 18'd250, 18'd400};
      do_start(12'd16);
      chk("t1_rd",   32'(mem_rd), 32'd1);
      chk("t1_addr", 32'(mem_addr), 32'd16);
      chk("t1_busy", 32'(busy), 32'd1);
      cyc(2);
      chk("t1_lat3", 32'(note_time), 32'h3FFFF);
      cyc(1);
      chk("t1_lat4", 32'(note_time), 32'd100);
      cyc(10);
      chk("t1_nrd", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t1_rdaddr", 32'(rd_log[i]), 32'(16+i));
      chk("t1_notdone", 32'(chart_done), 32'd0);

      // pop sequence, one pulse every 3 cycles
      while (exp_q.size() > 0) begin
         pop_one("t2_head");
         chk("t2_next", 32'(note_time), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h3FFFF);
         if (exp_q.size() == 0) begin
            chk("t2_done", 32'(chart_done), 32'd1);
            chk("t2_busy", 32'(busy), 32'd0);
         end
         cyc(2);
      end
      chk("t2_nrd", 32'(rd_log.size()), 32'd4);
      // request while DONE: no effect
      note_request = 1'b1; cyc(1); note_request = 1'b0; cyc(1);
      chk("t2_done_ur", 32'(underrun), 32'd0);
      chk("t2_done_hold", 32'(chart_done), 32'd1);

      // back-to-back requests
      for (int i = 0; i < 8; i++) exp_q.push_back(18'(1000 + 7*i));
      do_start(12'd200);
      cyc(10);
      for (int i = 0; i < 4; i++) begin
         chk("t3_b2b", 32'(note_time), 32'(exp_q.pop_front()));
         note_request = 1'b1;
         @(negedge clk);
      end
      note_request = 1'b0;
      while (exp_q.size() > 0) pop_one("t3_rest");
      wait_done("t3_done");

      // restart flush while old-chart reads are in flight
      exp_q.delete();
      do_start(12'd300);
      cyc(2);
      start = 1'b1; base_addr = 12'd64;
      @(negedge clk);
      start = 1'b0;
      exp_q = '{18'd7000, 18'd7001, 18'd7002};
      chk("t4_rd",   32'(mem_rd), 32'd1);
      chk("t4_addr", 32'(mem_addr), 32'd64);
      cyc(2);
      chk("t4_lat3", 32'(note_time), 32'h3FFFF);
      cyc(1);
      chk("t4_lat4", 32'(note_time), 32'd7000);
      while (exp_q.size() > 0) pop_one("t4_head");
      wait_done("t4_done");

      // address ceiling, no sentinel in memory
      rd_log.delete();
      exp_q = '{18'd11, 18'd22};
      do_start(12'd4094);
      cyc(8);
      chk("t5_nrd", 32'(rd_log.size()), 32'd2);
      for (int i = 0; i < 2 && i < rd_log.size(); i++) chk("t5_rdaddr", 32'(rd_log[i]), 32'(4094+i));
      chk("t5_nowrap", 32'(mem_addr), 32'd4095);
      while (exp_q.size() > 0) pop_one("t5_head");
      wait_done("t5_done");
      chk("t5_nrd_end", 32'(rd_log.size()), 32'd2);

      // request on empty FIFO while fetching
      exp_q = '{18'd100, 18'd250, 18'd400};
      do_start(12'd16);
      cyc(1);
      note_request = 1'b1;
      @(negedge clk);
      note_request = 1'b0;
      chk("t6_ur",   32'(underrun), 32'(UR_EXP));
      chk("t6_lat3", 32'(note_time), 32'h3FFFF);
      cyc(1);
      chk("t6_lat4", 32'(note_time), 32'd100);
      do_start(12'd16);
      chk("t6_urclr", 32'(underrun), 32'd0);
      while (exp_q.size() > 0) pop_one("t6_head");
      wait_done("t6_done");

      // asynchronous reset in mid-operation
      do_start(12'd200);
      cyc(1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rd",   32'(mem_rd), 32'd0);
      chk("t7_addr", 32'(mem_addr), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_nt",   32'(note_time), 32'h3FFFF);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
